rf_alu_exec_unit: RTL
=====================

// Module: rf_alu_exec_unit
// PURPOSE
//  Parametrised successor of the 16-bit register-file-plus-ALU datapath. Holds NREGS x WIDTH registers,
//  selects ALU operands (PC/reg A; reg B/+1/imm/disp) and issues operations via start/done handshake.
//  Adds registered result/flags, 8-op ALU and multi-cycle iterative multiply. Sits between decode/control FSM and memory.
// PARAMETERS
//  WIDTH   16  datapath and register width
//  NREGS   8   register count; AW = $clog2(NREGS) address bits
//  IMM_W   5   immediate field width, instr[IMM_W-1:0], zero-extended
//  DISP_W  8   displacement field width, instr[DISP_W-1:0], sign-extended; also instr port width
// PORTS
//  clk        in   1       clock, all state on rising edge
//  clr        in   1       synchronous active-low reset
//  wr_e       in   1       register write enable
//  wr_addr    in   AW      write address
//  wr_data    in   WIDTH   write data
//  rd_addr_a  in   AW      read port A address
//  rd_addr_b  in   AW      read port B address
//  rd_a       out  WIDTH   read data A (combinational)
//  rd_b       out  WIDTH   read data B (combinational)
//  mem_wd     out  WIDTH   store data = rd_b
//  pc         in   WIDTH   program counter operand
//  instr      in   DISP_W  immediate/displacement field
//  alu_srca   in   1       0: pc, 1: rd_a
//  alu_srcb   in   2       00 rd_b, 01 constant 1, 10 imm, 11 disp
//  alu_ctrl   in   3       000 AND,001 OR,010 ADD,011 SUB,100 SHL1,101 SHR1 logical,110 MUL,111 PASS B
//  e_flag     in   1       flag update enable, sampled at start
//  start      in   1       issue op; operands, alu_ctrl, e_flag latched this edge
//  busy       out  1       op in flight; start ignored while high
//  done       out  1       one-cycle pulse: alu_out/flags valid
//  alu_out    out  WIDTH   registered result, holds until next done
//  c,n,z,v    out  1       registered flags
// BEHAVIOUR
//  Reset (clr=0 at edge): all registers, alu_out, c/n/z/v, busy, done = 0; FSM -> IDLE. Wins over everything.
//  Reset mid-MUL aborts: no done, result discarded.
//  RF: write on rising edge when wr_e; all NREGS writable. Read asynchronous; same-cycle write/read returns old value.
//  FSM IDLE: start=1 -> latch A,B,op,e_flag. Non-MUL: EXEC one cycle -> IDLE, done=1 at t+1, busy=0 throughout.
//  MUL: IDLE->MUL, busy=1 at t+1; shift-add WIDTH cycles; done=1, busy=0 at t+WIDTH+1; alu_out = low WIDTH bits of A*B.
//  start during busy ignored; start on the done cycle is accepted (back-to-back issue).
//  Operands latched at start; RF writes during MUL do not affect the result.
//  ADD/SUB modulo 2^WIDTH. c: ADD carry-out, SUB no-borrow (A>=B unsigned), SHL msb out, SHR lsb out, else 0.
//  v: signed overflow for ADD/SUB, else 0. n = result[WIDTH-1]; z = (result==0).
//  Flags update only with done and latched e_flag=1; otherwise hold. alu_out updates on every done.
//  imm = {0, instr[IMM_W-1:0]}; disp = sign-extended instr[DISP_W-1:0].
// CONFIGURATION
//  RF_ALU_BYPASS_EN defined: write forwarding; wr_e && wr_addr==rd_addr_x -> rd_x (and mem_wd) = wr_data same cycle,
//   also into operands latched at start.
//  Undefined: rd_x shows stored (old) value until after the write edge.
// TESTING (WIDTH=16, NREGS=8)
//  Reset, write R1=1234, R2=1111; start ADD srca=1 srcb=00 a=1 b=2 -> next cycle done=1, alu_out=2345, c=n=z=v=0.
//  R2+imm instr=04 -> 1115; R1+disp instr=34 -> 1268; R1+disp instr=FF -> 1233; pc=1000 srca=0 srcb=01 -> 1001.
//  SUB R2-R1 -> FEDD, n=1 c=0 v=0; R1=7FFF ADD +1 -> 8000, v=1 n=1; SUB R1-R1 e_flag=0 -> 0000, flags unchanged.
//  MUL R3=0003,R4=0005: busy t+1..t+16, done t+17, alu_out=000F; start at t+5 ignored; write R3 at t+3 no effect.
//  clr low at t+8 of MUL -> busy=0, done=0, alu_out=0, all regs 0; no done pulse afterwards.
//  wr_e R5=ABCD with rd_addr_a=5 same cycle -> rd_a=ABCD with RF_ALU_BYPASS_EN, 0000 without; ABCD next cycle both.

Source files
------------

// File: rtl/rf_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// rf_alu_exec_unit
//
// Register file plus ALU execution datapath. It holds NREGS x WIDTH
// registers, selects the ALU operands (PC or read port A; read port B,
// constant 1, zero-extended immediate or sign-extended displacement), and
// runs operations through a start/done handshake. The result and the
// c/n/z/v flags are registered. MUL is a WIDTH-cycle shift-add iteration;
// every other operation completes in a single cycle.
//
// Ports
//   clk                    clock, all state updates on the rising edge
//   clr                    synchronous active-low reset
//   wr_e/wr_addr/wr_data   register file write port
//   rd_addr_a/rd_addr_b    asynchronous read port addresses
//   rd_a/rd_b              read data (combinational)
//   mem_wd                 store data, always equal to rd_b
//   pc                     program counter operand
//   instr                  immediate/displacement field
//   alu_srca               0: pc, 1: rd_a
//   alu_srcb               00 rd_b, 01 constant 1, 10 imm, 11 disp
//   alu_ctrl               000 AND, 001 OR, 010 ADD, 011 SUB,
//                          100 SHL1, 101 SHR1, 110 MUL, 111 PASS B
//   e_flag                 flag update enable, captured with start
//   start                  issue an operation (ignored while busy)
//   busy                   multiply in flight
//   done                   one-cycle pulse, alu_out and flags valid
//   alu_out                registered result
//   c, n, z, v             registered flags
//
// Configuration macro
//   RF_ALU_BYPASS_EN  when defined, a write to the register being read is
//                     forwarded to rd_a/rd_b/mem_wd in the same cycle, and
//                     therefore also into operands captured by start.
// ---------------------------------------------------------------------------
module rf_alu_exec_unit #(
    parameter  int WIDTH  = 16,
    parameter  int NREGS  = 8,
    parameter  int IMM_W  = 5,
    parameter  int DISP_W = 8,
    localparam int AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_e,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [WIDTH-1:0]  rd_a,
    output logic [WIDTH-1:0]  rd_b,
    output logic [WIDTH-1:0]  mem_wd,
    input  logic [WIDTH-1:0]  pc,
    input  logic [DISP_W-1:0] instr,
    input  logic              alu_srca,
    input  logic [1:0]        alu_srcb,
    input  logic [2:0]        alu_ctrl,
    input  logic              e_flag,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  alu_out,
    output logic              c,
    output logic              n,
    output logic              z,
    output logic              v
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_MUL  = 3'b110,
        OP_PASS = 3'b111
    } alu_op_e;

    // S_EXEC is the cycle in which done is high; it accepts a new start just
    // like S_IDLE, which gives back-to-back issue.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_e;

    typedef struct packed {
        logic c;
        logic n;
        logic z;
        logic v;
    } flags_t;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] regs_q [NREGS];

    // NOTE: the register array is cleared by reset because the datapath
    // must come up with every register reading zero; memories without that
    // requirement are normally left unreset so they can map to RAM.
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_e) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

`ifdef RF_ALU_BYPASS_EN
    assign rd_a = (wr_e && (wr_addr == rd_addr_a)) ? wr_data : regs_q[rd_addr_a];
    assign rd_b = (wr_e && (wr_addr == rd_addr_b)) ? wr_data : regs_q[rd_addr_b];
`else
    assign rd_a = regs_q[rd_addr_a];
    assign rd_b = regs_q[rd_addr_b];
`endif

    assign mem_wd = rd_b;

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] disp_ext;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    assign imm_ext  = {{(WIDTH - IMM_W){1'b0}}, instr[IMM_W-1:0]};
    assign disp_ext = {{(WIDTH - DISP_W){instr[DISP_W-1]}}, instr};
    assign op_a     = alu_srca ? rd_a : pc;

    always_comb begin
        unique case (alu_srcb)
            2'b00:   op_b = rd_b;
            2'b01:   op_b = WIDTH'(1);
            2'b10:   op_b = imm_ext;
            default: op_b = disp_ext;
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle ALU (MUL result comes from the iterative path)
    // ------------------------------------------------------------------
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] alu_res;
    flags_t           alu_flags;

    // NOTE: every output of a combinational block gets a default at the top
    // so no path through the case leaves it unassigned (which would infer a
    // latch).
    always_comb begin
        sum_ext     = '0;
        alu_res     = '0;
        alu_flags   = '0;
        unique case (alu_op_e'(alu_ctrl))
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_ADD: begin
                sum_ext     = {1'b0, op_a} + {1'b0, op_b};
                alu_res     = sum_ext[MSB:0];
                alu_flags.c = sum_ext[WIDTH];
                alu_flags.v = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                // a + ~b + 1: the carry out is set exactly when a >= b.
                sum_ext     = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH + 1)'(1);
                alu_res     = sum_ext[MSB:0];
                alu_flags.c = sum_ext[WIDTH];
                alu_flags.v = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            OP_SHL: begin
                alu_res     = {op_a[MSB-1:0], 1'b0};
                alu_flags.c = op_a[MSB];
            end
            OP_SHR: begin
                alu_res     = {1'b0, op_a[MSB:1]};
                alu_flags.c = op_a[0];
            end
            OP_PASS: alu_res = op_b;
            default: alu_res = '0;
        endcase
        alu_flags.n = alu_res[MSB];
        alu_flags.z = (alu_res == '0);
    end

    // ------------------------------------------------------------------
    // Control FSM and iterative multiplier
    // ------------------------------------------------------------------
    state_e           state_q,   state_d;
    logic [WIDTH-1:0] mcand_q,   mcand_d;
    logic [WIDTH-1:0] mplier_q,  mplier_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic             ef_q,      ef_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    flags_t           flags_q,   flags_d;
    logic [WIDTH-1:0] acc_step;

    // One shift-add step; the multiplicand is shifted left each cycle so only
    // the low WIDTH bits of the product are ever formed.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ef_d      = ef_q;
        alu_out_d = alu_out_q;
        flags_d   = flags_q;

        unique case (state_q)
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_EXEC;
                    alu_out_d = acc_step;
                    if (ef_q) begin
                        flags_d = '{c: 1'b0, n: acc_step[MSB], z: (acc_step == '0), v: 1'b0};
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                if (start) begin
                    if (alu_op_e'(alu_ctrl) == OP_MUL) begin
                        state_d  = S_MUL;
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        ef_d     = e_flag;
                    end else begin
                        // Single-cycle ops are captured straight into the
                        // result register, so done follows on the next cycle.
                        state_d   = S_EXEC;
                        alu_out_d = alu_res;
                        if (e_flag) begin
                            flags_d = alu_flags;
                        end
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ef_q      <= 1'b0;
            alu_out_q <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ef_q      <= ef_d;
            alu_out_q <= alu_out_d;
            flags_q   <= flags_d;
        end
    end

    assign busy    = (state_q == S_MUL);
    assign done    = (state_q == S_EXEC);
    assign alu_out = alu_out_q;
    assign c       = flags_q.c;
    assign n       = flags_q.n;
    assign z       = flags_q.z;
    assign v       = flags_q.v;

endmodule
